// File: rtl/otp_pkg.sv
// Shared types and defaults for the OTP byte sequencer.
package otp_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      HOLD  = 2'd3
   } seq_state_t;

   localparam int START_CYCLES_DEF   = 2;
   localparam int TIMEOUT_CYCLES_DEF = 1024;

   // Width of a counter that must hold 0 .. n-1.
   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/otp_done_sync.sv
// Two-flop synchronizer for the engine done level plus rising-edge detect.
// Latency: sync_rise asserts two clk edges after async_in rises; no backpressure.
// A level already high produces no pulse until it falls and rises again.
module otp_done_sync (
   input  logic clk,
   input  logic reset_n,
   input  logic async_in,
   output logic sync_rise
);

   // [0],[1] form the synchronizer; [2] is the previous synchronized value.
   logic [2:0] sync_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= 3'b000;
      end else begin
         sync_q <= {sync_q[1:0], async_in};
      end
   end

   assign sync_rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/otp_byte_sequencer.sv
// Feeds one byte at a time to the OTP engine and returns its result downstream.
// Latency: capture, START_CYCLES of eng_start, then result 3 clk after eng_done rises.
// Backpressure: holds the result in HOLD until out_ready; in_ready low while a byte is in flight.
module otp_byte_sequencer
   import otp_pkg::*;
#(
   parameter int START_CYCLES   = START_CYCLES_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_data,
   input  logic        in_passthrough,
   output logic [7:0]  eng_data,
   output logic        eng_passthrough,
   output logic        eng_start,
   input  logic        eng_done,
   input  logic [7:0]  eng_result,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  out_data,
   output logic        err_timeout,
   output logic [15:0] byte_count
);

   localparam int SW = cnt_width(START_CYCLES);
   localparam int TW = cnt_width(TIMEOUT_CYCLES);
   localparam logic [SW-1:0] START_LAST   = SW'(START_CYCLES - 1);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

   seq_state_t    state;
   seq_state_t    state_nxt;
   logic [SW-1:0] start_cnt;
   logic [TW-1:0] wait_cnt;
   logic          done_rise;
   logic          accept;
   logic          start_last;
   logic          timeout_hit;
   logic          deliver;

   otp_done_sync u_done_sync (
      .clk       (clk),
      .reset_n   (reset_n),
      .async_in  (eng_done),
      .sync_rise (done_rise)
   );

   assign accept      = in_valid && (state == IDLE);
   assign start_last  = (start_cnt == START_LAST);
   assign timeout_hit = (wait_cnt == TIMEOUT_LAST);
   assign deliver     = (state == HOLD) && out_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      eng_start = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_nxt = START;
            end
         end
         START: begin
            eng_start = 1'b1;
            if (start_last) begin
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            // Completion takes priority over a coincident timeout.
            if (done_rise) begin
               state_nxt = HOLD;
            end else if (timeout_hit) begin
               state_nxt = IDLE;
            end
         end
         HOLD: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Both counters sit at zero outside their state, so entry always starts from zero.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         start_cnt <= '0;
         wait_cnt  <= '0;
      end else begin
         if ((state == START) && !start_last) begin
            start_cnt <= start_cnt + 1'b1;
         end else begin
            start_cnt <= '0;
         end
         if (state == WAIT) begin
            wait_cnt <= wait_cnt + 1'b1;
         end else begin
            wait_cnt <= '0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         eng_data        <= 8'h00;
         eng_passthrough <= 1'b0;
         out_data        <= 8'h00;
         err_timeout     <= 1'b0;
         byte_count      <= 16'h0000;
      end else begin
         if (accept) begin
            eng_data        <= in_data;
            eng_passthrough <= in_passthrough;
         end
         if ((state == WAIT) && done_rise) begin
            out_data <= eng_result;
         end
         if ((state == WAIT) && !done_rise && timeout_hit) begin
            err_timeout <= 1'b1;
         end
         if (deliver) begin
            byte_count <= byte_count + 16'd1;
         end
      end
   end

endmodule
